// File: rtl/axi_stream_flux_pkg.sv
// Shared definitions for the flux capture stream: word layout, capture modes
// and controller states.
package axi_stream_flux_pkg;

    localparam int TS_WIDTH     = 28;
    localparam int WORD_WIDTH   = 32;
    localparam int WORD_IDX_BIT = 31;
    localparam int WORD_OVF_BIT = 30;

    localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

    typedef enum logic [1:0] {
        MODE_CONTINUOUS     = 2'b00,
        MODE_TRACK          = 2'b01,
        MODE_ONE_REV        = 2'b10,
        MODE_CONTINUOUS_ALT = 2'b11
    } capture_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

    function automatic logic [WORD_WIDTH-1:0] packWord(
        input logic                idx,
        input logic                ovf,
        input logic [TS_WIDTH-1:0] ts
    );
        logic [WORD_WIDTH-1:0] w;
        w               = '0;
        w[WORD_IDX_BIT] = idx;
        w[WORD_OVF_BIT] = ovf;
        w[TS_WIDTH-1:0] = ts;
        return w;
    endfunction

endpackage

// File: rtl/axi_stream_flux_fifo.sv
// First-word-fall-through synchronous FIFO holding captured flux words; the
// head word is visible on rdata_o whenever the FIFO is not empty.
module flux_fifo
    import axi_stream_flux_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter int ADDR_BITS = 9,
    parameter int WIDTH     = WORD_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [ADDR_BITS:0]   level_o
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS:0]   FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_BITS-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 doPush;
    logic                 doPop;

    assign full_o  = (count_q == FULL_LEVEL);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == LAST_ADDR) ? '0 : wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == LAST_ADDR) ? '0 : rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_stream_flux.sv
// Floppy flux capture: timestamps synchronized flux/index edges and streams
// the resulting words out over AXI-Stream through a FWFT FIFO.
module axi_stream_flux
    import axi_stream_flux_pkg::*;
#(
    parameter int FIFO_DEPTH     = 512,
    parameter int FIFO_ADDR_BITS = 9,
    parameter int CLK_DIV        = 56
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      flux_raw,
    input  logic                      index_pulse,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [3:0]                m_axis_tkeep,
    input  logic                      capture_enable,
    input  logic                      soft_reset,
    input  logic [1:0]                capture_mode,
    output logic [31:0]               capture_count,
    output logic [15:0]               index_count,
    output logic                      overflow,
    output logic                      capturing,
    output logic                      fifo_empty,
    output logic [FIFO_ADDR_BITS:0]   fifo_level
);

    // CLK_DIV documents the reference ratio only; no logic depends on it.
    if (CLK_DIV < 1) begin : gClkDivUnused
    end

    logic fluxMeta_q, fluxSync_q, fluxPrev_q;
    logic idxMeta_q, idxSync_q, idxPrev_q;
    logic fluxEvt, idxEvt, capActive, anyEvt, pushEvt, dropEvt;

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] interval_q;
    logic [31:0]         captureCount_q;
    logic [15:0]         indexCount_q;
    logic                overflow_q;
    logic                ovfPending_q;

    logic [WORD_WIDTH-1:0] fifoHead;
    logic                  fifoFull;
    logic                  fifoEmpty;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fluxMeta_q <= 1'b0;
            fluxSync_q <= 1'b0;
            fluxPrev_q <= 1'b0;
            idxMeta_q  <= 1'b0;
            idxSync_q  <= 1'b0;
            idxPrev_q  <= 1'b0;
        end else begin
            fluxMeta_q <= flux_raw;
            fluxSync_q <= fluxMeta_q;
            fluxPrev_q <= fluxSync_q;
            idxMeta_q  <= index_pulse;
            idxSync_q  <= idxMeta_q;
            idxPrev_q  <= idxSync_q;
        end
    end

    assign fluxEvt   = fluxSync_q && !fluxPrev_q;
    assign idxEvt    = idxSync_q && !idxPrev_q;
    assign capActive = (state_q == ST_CAPTURE);
    assign anyEvt    = capActive && (fluxEvt || idxEvt);
    assign pushEvt   = anyEvt && !fifoFull;
    assign dropEvt   = anyEvt && fifoFull;

    always_ff @(posedge aclk) begin
        if (!aresetn || soft_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One-revolution mode stops only once the index word is actually stored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_enable) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!capture_enable) begin
                    state_d = ST_IDLE;
                end else if (pushEvt && idxEvt && (capture_mode == MODE_ONE_REV)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!capture_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || soft_reset) begin
            interval_q     <= '0;
            captureCount_q <= '0;
            indexCount_q   <= '0;
            overflow_q     <= 1'b0;
            ovfPending_q   <= 1'b0;
        end else begin
            if (capActive) begin
                if (fluxEvt || idxEvt) begin
                    interval_q <= TS_WIDTH'(1);
                end else if (interval_q != TS_MAX) begin
                    interval_q <= interval_q + 1'b1;
                end
            end
            if (capActive && fluxEvt) captureCount_q <= captureCount_q + 32'd1;
            if (capActive && idxEvt)  indexCount_q   <= indexCount_q + 16'd1;
            if (dropEvt) begin
                overflow_q   <= 1'b1;
                ovfPending_q <= 1'b1;
            end else if (pushEvt) begin
                ovfPending_q <= 1'b0;
            end
        end
    end

    flux_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .ADDR_BITS (FIFO_ADDR_BITS),
        .WIDTH     (WORD_WIDTH)
    ) uFifo (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .clear_i (soft_reset),
        .push_i  (pushEvt),
        .wdata_i (packWord(idxEvt, ovfPending_q, interval_q)),
        .pop_i   (m_axis_tvalid && m_axis_tready),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    assign m_axis_tvalid = !fifoEmpty;
    assign m_axis_tdata  = fifoEmpty ? '0 : fifoHead;
    assign m_axis_tlast  = !fifoEmpty && fifoHead[WORD_IDX_BIT] &&
                           ((capture_mode == MODE_TRACK) || (capture_mode == MODE_ONE_REV));
    assign m_axis_tkeep  = 4'hF;
    assign capture_count = captureCount_q;
    assign index_count   = indexCount_q;
    assign overflow      = overflow_q;
    assign capturing     = capActive;
    assign fifo_empty    = fifoEmpty;

endmodule

// File: tb/tb_axi_stream_flux.sv
// Self-checking bench for axi_stream_flux: table-driven pulse vectors plus
// hand-written overflow, soft-reset and one-revolution sequences.
module tb_axi_stream_flux;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        flux_raw;
    logic        index_pulse;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic        capture_enable;
    logic        soft_reset;
    logic [1:0]  capture_mode;
    logic [31:0] capture_count;
    logic [15:0] index_count;
    logic        overflow;
    logic        capturing;
    logic        fifo_empty;
    logic [9:0]  fifo_level;

    always #5 aclk = ~aclk;

    axi_stream_flux #(
        .FIFO_DEPTH     (512),
        .FIFO_ADDR_BITS (9),
        .CLK_DIV        (56)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .flux_raw       (flux_raw),
        .index_pulse    (index_pulse),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tkeep   (m_axis_tkeep),
        .capture_enable (capture_enable),
        .soft_reset     (soft_reset),
        .capture_mode   (capture_mode),
        .capture_count  (capture_count),
        .index_count    (index_count),
        .overflow       (overflow),
        .capturing      (capturing),
        .fifo_empty     (fifo_empty),
        .fifo_level     (fifo_level)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic        last;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic        flux;
        logic        idx;
        int          width;
        int          gap;
        logic        maskTs;
        logic [27:0] expTs;
        logic        expLast;
        int          expCc;
        int          expIc;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[17];
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   lat;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic idx, input logic ovf, input logic [27:0] ts,
                           input logic maskTs, input logic last);
        exp_t e;
        e.data = {idx, ovf, 2'b00, ts};
        e.mask = maskTs ? 32'hF000_0000 : 32'hFFFF_FFFF;
        e.last = last;
        sbQ.push_back(e);
    endtask

    // Inputs only change at negedges, so values seen at negedge+1 are the
    // ones the next rising edge will use for the handshake.
    task automatic tick();
        exp_t e;
        #1;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (sbQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL sb_unexpected_word: got 0x%08h, expected no word", m_axis_tdata);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_data", m_axis_tdata & e.mask, e.data & e.mask);
                checkOutput("sb_tlast", {31'b0, m_axis_tlast}, {31'b0, e.last});
            end
        end
        @(negedge aclk);
    endtask

    task automatic applyStimulus(input logic flux, input logic idx, input int width,
                                 input int gap);
        flux_raw    = flux;
        index_pulse = idx;
        repeat (width) tick();
        flux_raw    = 1'b0;
        index_pulse = 1'b0;
        repeat (gap - width) tick();
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{2'b00, 1'b1, 1'b0, 1, 102, (i == 0), 28'd102, 1'b0, i + 1, 0};
        end
        vecs[10] = '{2'b01, 1'b0, 1'b1, 10, 40, 1'b0, 28'd102, 1'b1, 10, 1};
        vecs[11] = '{2'b01, 1'b1, 1'b0, 1,  30, 1'b0, 28'd40,  1'b0, 11, 1};
        vecs[12] = '{2'b11, 1'b1, 1'b0, 3,  25, 1'b0, 28'd30,  1'b0, 12, 1};
        vecs[13] = '{2'b11, 1'b0, 1'b1, 2,  20, 1'b0, 28'd25,  1'b0, 12, 2};
        vecs[14] = '{2'b00, 1'b1, 1'b0, 1,  17, 1'b0, 28'd20,  1'b0, 13, 2};
        vecs[15] = '{2'b01, 1'b0, 1'b1, 1,  60, 1'b0, 28'd17,  1'b1, 13, 3};
        vecs[16] = '{2'b00, 1'b1, 1'b1, 1,  30, 1'b0, 28'd60,  1'b0, 14, 4};

        aresetn        = 1'b0;
        flux_raw       = 1'b0;
        index_pulse    = 1'b0;
        m_axis_tready  = 1'b0;
        capture_enable = 1'b0;
        soft_reset     = 1'b0;
        capture_mode   = 2'b00;
        repeat (3) tick();
        checkOutput("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        checkOutput("rst_tdata", m_axis_tdata, 32'd0);
        checkOutput("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        checkOutput("rst_fifo_level", {22'b0, fifo_level}, 32'd0);
        checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);

        aresetn = 1'b1;
        repeat (2) tick();
        checkOutput("idle_capturing", {31'b0, capturing}, 32'd0);
        checkOutput("idle_fifo_empty", {31'b0, fifo_empty}, 32'd1);
        checkOutput("idle_capture_count", capture_count, 32'd0);
        checkOutput("idle_index_count", {16'b0, index_count}, 32'd0);
        checkOutput("idle_tkeep", {28'b0, m_axis_tkeep}, 32'hF);

        capture_enable = 1'b1;
        m_axis_tready  = 1'b1;
        for (int i = 0; i < 2 && !capturing; i++) tick();
        checkOutput("enable_capturing", {31'b0, capturing}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            capture_mode = vecs[i].mode;
            pushExp(vecs[i].idx, 1'b0, vecs[i].expTs, vecs[i].maskTs, vecs[i].expLast);
            applyStimulus(vecs[i].flux, vecs[i].idx, vecs[i].width, vecs[i].gap);
            checkOutput("vec_capture_count", capture_count, vecs[i].expCc);
            checkOutput("vec_index_count", {16'b0, index_count}, vecs[i].expIc);
        end

        // Back-pressure: first pulse also measures edge-to-tvalid latency.
        m_axis_tready = 1'b0;
        capture_mode  = 2'b00;
        pushExp(1'b0, 1'b0, 28'd0, 1'b1, 1'b0);
        flux_raw = 1'b1;
        lat = 0;
        for (int i = 0; i < 6 && !m_axis_tvalid; i++) begin
            tick();
            lat++;
            flux_raw = 1'b0;
        end
        nCompared++;
        if (!m_axis_tvalid || lat > 5) begin
            nMismatched++;
            $display("[TB] FAIL flux_latency: got %0d cycles (tvalid=%0b), expected <= 5", lat, m_axis_tvalid);
        end
        repeat (4) tick();
        for (int p = 1; p < 650; p++) begin
            if (p < 512) pushExp(1'b0, 1'b0, 28'd4, (p == 1), 1'b0);
            applyStimulus(1'b1, 1'b0, 1, 4);
            if (p == 49) begin
                checkOutput("bp_level_50", {22'b0, fifo_level}, 32'd50);
                checkOutput("bp_no_overflow", {31'b0, overflow}, 32'd0);
                checkOutput("bp_count_50", capture_count, 32'd64);
            end
        end
        checkOutput("bp_level_full", {22'b0, fifo_level}, 32'd512);
        checkOutput("bp_overflow", {31'b0, overflow}, 32'd1);
        checkOutput("bp_count_650", capture_count, 32'd664);

        m_axis_tready = 1'b1;
        repeat (520) tick();
        checkOutput("drain_fifo_empty", {31'b0, fifo_empty}, 32'd1);
        checkOutput("drain_queue_empty", sbQ.size(), 32'd0);
        pushExp(1'b0, 1'b1, 28'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1, 10);
        checkOutput("ovf_count", capture_count, 32'd665);
        checkOutput("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Soft reset with words still queued.
        m_axis_tready = 1'b0;
        repeat (5) applyStimulus(1'b1, 1'b0, 1, 4);
        checkOutput("sr_level_before", {22'b0, fifo_level}, 32'd5);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checkOutput("sr_fifo_empty", {31'b0, fifo_empty}, 32'd1);
        checkOutput("sr_fifo_level", {22'b0, fifo_level}, 32'd0);
        checkOutput("sr_capture_count", capture_count, 32'd0);
        checkOutput("sr_index_count", {16'b0, index_count}, 32'd0);
        checkOutput("sr_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("sr_capturing", {31'b0, capturing}, 32'd0);
        tick();
        checkOutput("sr_recapture", {31'b0, capturing}, 32'd1);
        m_axis_tready = 1'b1;
        pushExp(1'b0, 1'b0, 28'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1, 10);
        checkOutput("sr_next_count", capture_count, 32'd1);

        // One-revolution mode stops after the index word.
        capture_mode = 2'b10;
        for (int p = 0; p < 100; p++) begin
            pushExp(1'b0, 1'b0, 28'd5, (p == 0), 1'b0);
            applyStimulus(1'b1, 1'b0, 1, 5);
        end
        pushExp(1'b1, 1'b0, 28'd5, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2, 10);
        checkOutput("rev_index_count", {16'b0, index_count}, 32'd1);
        checkOutput("rev_capture_count", capture_count, 32'd101);
        checkOutput("rev_done_capturing", {31'b0, capturing}, 32'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1, 5);
        checkOutput("rev_ignored_count", capture_count, 32'd101);
        checkOutput("rev_ignored_empty", {31'b0, fifo_empty}, 32'd1);
        capture_enable = 1'b0;
        repeat (2) tick();
        capture_enable = 1'b1;
        for (int i = 0; i < 2 && !capturing; i++) tick();
        checkOutput("rev_restart", {31'b0, capturing}, 32'd1);
        pushExp(1'b0, 1'b0, 28'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1, 10);
        checkOutput("rev_restart_count", capture_count, 32'd102);

        repeat (10) tick();
        checkOutput("final_queue_empty", sbQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
